intra4x4_nbr_loader: RTL and testbench
======================================

// Module: intra4x4_nbr_loader
// PURPOSE
//  Gathers the 13 reference samples (M, A..H, I..L) for one 4x4 luma intra block from a serial
//  neighbour-sample stream, applying availability substitution. Sits directly upstream of the
//  4x4 luma intra predictors (DDL, DDR, V, H, DC ...) and presents A..M as a registered, stable bundle.
//  Runs one block at a time, with a start handshake, a sample valid/ready stream and an output valid/ready.
// PARAMETERS
//  SAMPLE_W    8     bit width of one sample
//  FILL_VALUE  128   substitute for unavailable samples (1<<(SAMPLE_W-1))
// PORTS
//  clk           in   1         single clock, rising edge
//  reset         in   1         synchronous, active-high
//  start         in   1         request to load one block's neighbours
//  start_ready   out  1         high only in IDLE; start accepted when start&&start_ready
//  top_avail     in   1         A..D available; sampled with accepted start
//  tr_avail      in   1         E..H available; sampled with accepted start
//  left_avail    in   1         I..L available; sampled with accepted start
//  tl_avail      in   1         M available; sampled with accepted start
//  nb_valid      in   1         stream sample valid
//  nb_ready      out  1         loader can take a sample (high only in fetch states)
//  nb_data       in   SAMPLE_W  stream sample; transfer when nb_valid&&nb_ready
//  A..M          out  SAMPLE_W  13 registered reference samples (same lettering as predictors)
//  out_valid     out  1         A..M complete and stable
//  out_ready     in   1         consumer has taken bundle when out_valid&&out_ready
// BEHAVIOUR
//  - Reset: state=IDLE; A..M=0, out_valid=0, nb_ready=0, start_ready=1 in first cycle after reset.
//  - FSM: IDLE -> F_TL -> F_TOP -> F_TR -> F_LEFT -> OUT -> IDLE. A fetch state whose group is
//    unavailable is skipped in the same cycle it would be entered (no dead cycles).
//  - Stream order only covers available groups: M, then A,B,C,D, then E,F,G,H, then I,J,K,L.
//  - 2-bit index counter within a group; advances only on transfer; stalls while nb_valid=0.
//  - Substitution, written when the group is skipped or at start:
//    tl_avail=0 -> M=FILL_VALUE; top_avail=0 -> A..H=FILL_VALUE (tr_avail ignored);
//    top_avail=1,tr_avail=0 -> E,F,G,H = D (value of D as received); left_avail=0 -> I..L=FILL_VALUE.
//  - Latency: out_valid rises the cycle after the last transfer; with all flags 0, one cycle after start.
//    Full load with no stalls: 13 transfer cycles + 1.
//  - OUT: A..M and out_valid held until out_ready; on handshake -> IDLE, out_valid=0 next cycle,
//    A..M retain values until overwritten by the next load.
//  - start while not IDLE: ignored (start_ready=0); availability flags ignored outside the start handshake.
//  - nb_valid in IDLE/OUT: no transfer (nb_ready=0), sample not consumed.
//  - Reset mid-load or in OUT: abort, all outputs to reset values; partial data discarded.
//  - No arithmetic; all outputs exactly SAMPLE_W, no width growth.
// CONFIGURATION
//  Macro INTRA4X4_NBR_BLKCNT_EN:
//   defined  -> extra output blk_count[15:0]: +1 on each out_valid&&out_ready, wraps 0xFFFF->0, reset 0.
//   undefined -> port and counter absent; all other behaviour identical.
// STRUCTURE
//  Shared package intra_pkg: SAMPLE_W/FILL_VALUE constants, nbr_state_t enum
//  (IDLE,F_TL,F_TOP,F_TR,F_LEFT,OUT), nbr_group_t indices shared with the predictor stages.
//  Single module; no sub-module needed (FSM + 13-entry register file + 2-bit counter).
// TESTING
//  1 all avail, stream M=10,A..H=20..27,I..L=30..33, no stalls -> out_valid 14 cycles after start, values exact.
//  2 tr_avail=0, stream M,A..D=5,6,7,8,I..L -> nb_ready drops after 9 transfers; E..H=8.
//  3 all flags 0 -> no nb_ready, out_valid 1 cycle after start, A..M=128.
//  4 random nb_valid gaps + out_ready low 5 cycles -> same values; A..M stable while out_valid held.
//  5 reset asserted after 6 transfers -> next cycle out_valid=0, A..M=0, start_ready=1; fresh load correct.
//  6 start pulsed during fetch and OUT -> ignored; with INTRA4X4_NBR_BLKCNT_EN, 3 loads -> blk_count=3.

Source files
------------

// File: rtl/intra4x4_nbr_loader_pkg.sv
// Shared constants and types for the 4x4 luma intra neighbour loader and the predictor stages.
package intra_pkg;

  localparam int SAMPLE_W = 8;
  localparam logic [SAMPLE_W-1:0] FILL_VALUE = SAMPLE_W'(1 << (SAMPLE_W - 1));
  localparam int NUM_NBR = 13;

  typedef enum logic [2:0] {
    IDLE,
    F_TL,
    F_TOP,
    F_TR,
    F_LEFT,
    OUT
  } nbr_state_t;

  typedef enum logic [1:0] {
    GRP_TL,
    GRP_TOP,
    GRP_TR,
    GRP_LEFT
  } nbr_group_t;

  // Register-file slot order is M, A..H, I..L.
  function automatic logic [3:0] nbr_slot(nbr_group_t grp, logic [1:0] idx);
    case (grp)
      GRP_TL:  return 4'd0;
      GRP_TOP: return 4'd1 + {2'b00, idx};
      GRP_TR:  return 4'd5 + {2'b00, idx};
      default: return 4'd9 + {2'b00, idx};
    endcase
  endfunction

endpackage

// File: rtl/intra4x4_nbr_loader_if.sv
// Start, neighbour-stream and reference-bundle handshakes between the upstream feeder,
// the 4x4 intra neighbour loader and the predictors.
interface intra4x4_nbr_loader_if;
  import intra_pkg::*;

  logic start;
  logic start_ready;
  logic top_avail;
  logic tr_avail;
  logic left_avail;
  logic tl_avail;

  logic nb_valid;
  logic nb_ready;
  logic [SAMPLE_W-1:0] nb_data;

  logic [SAMPLE_W-1:0] A, B, C, D, E, F, G, H, I, J, K, L, M;
  logic out_valid;
  logic out_ready;

  modport master (
    output start, top_avail, tr_avail, left_avail, tl_avail,
    output nb_valid, nb_data, out_ready,
    input  start_ready, nb_ready, out_valid,
    input  A, B, C, D, E, F, G, H, I, J, K, L, M
  );

  modport slave (
    input  start, top_avail, tr_avail, left_avail, tl_avail,
    input  nb_valid, nb_data, out_ready,
    output start_ready, nb_ready, out_valid,
    output A, B, C, D, E, F, G, H, I, J, K, L, M
  );

endinterface

// File: rtl/intra4x4_nbr_loader.sv
// Loads the 13 reference samples of one 4x4 luma intra block with availability substitution.
// Optional block counter output enabled by defining INTRA4X4_NBR_BLKCNT_EN.
module intra4x4_nbr_loader
  import intra_pkg::*;
(
  input  logic clk,
  input  logic reset,
  intra4x4_nbr_loader_if.slave bus
`ifdef INTRA4X4_NBR_BLKCNT_EN
  ,
  output logic [15:0] blk_count
`endif
);

  nbr_state_t state, state_next;
  nbr_group_t cur_grp;
  logic [1:0] idx;
  logic top_q, tr_q, left_q;
  logic [SAMPLE_W-1:0] smp [NUM_NBR];

  logic start_acc, xfer, out_acc, grp_done;

  assign start_acc = bus.start && bus.start_ready;
  assign xfer      = bus.nb_valid && bus.nb_ready;
  assign out_acc   = bus.out_valid && bus.out_ready;
  assign grp_done  = xfer && ((state == F_TL) || (idx == 2'd3));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Unavailable groups are skipped while choosing the next state, so no dead cycles occur.
  always_comb begin
    state_next      = state;
    cur_grp         = GRP_TL;
    bus.start_ready = 1'b0;
    bus.nb_ready    = 1'b0;
    bus.out_valid   = 1'b0;
    case (state)
      IDLE: begin
        bus.start_ready = 1'b1;
        if (start_acc) begin
          if (bus.tl_avail)        state_next = F_TL;
          else if (bus.top_avail)  state_next = F_TOP;
          else if (bus.left_avail) state_next = F_LEFT;
          else                     state_next = OUT;
        end
      end
      F_TL: begin
        bus.nb_ready = 1'b1;
        if (grp_done) begin
          if (top_q)       state_next = F_TOP;
          else if (left_q) state_next = F_LEFT;
          else             state_next = OUT;
        end
      end
      F_TOP: begin
        bus.nb_ready = 1'b1;
        cur_grp      = GRP_TOP;
        if (grp_done) begin
          if (tr_q)        state_next = F_TR;
          else if (left_q) state_next = F_LEFT;
          else             state_next = OUT;
        end
      end
      F_TR: begin
        bus.nb_ready = 1'b1;
        cur_grp      = GRP_TR;
        if (grp_done) state_next = left_q ? F_LEFT : OUT;
      end
      F_LEFT: begin
        bus.nb_ready = 1'b1;
        cur_grp      = GRP_LEFT;
        if (grp_done) state_next = OUT;
      end
      OUT: begin
        bus.out_valid = 1'b1;
        if (out_acc) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // tr_q already folds in top availability, since E..H are never fetched without A..D.
  always_ff @(posedge clk) begin
    if (reset) begin
      top_q  <= 1'b0;
      tr_q   <= 1'b0;
      left_q <= 1'b0;
    end else if (start_acc) begin
      top_q  <= bus.top_avail;
      tr_q   <= bus.top_avail && bus.tr_avail;
      left_q <= bus.left_avail;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)          idx <= 2'd0;
    else if (start_acc) idx <= 2'd0;
    else if (xfer)      idx <= (state == F_TL) ? 2'd0 : idx + 2'd1;
  end

  // Fill values land at start; a missing top-right group copies D as it arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_NBR; i++) smp[i] <= '0;
    end else if (start_acc) begin
      if (!bus.tl_avail) smp[0] <= FILL_VALUE;
      if (!bus.top_avail) begin
        for (int i = 1; i <= 8; i++) smp[i] <= FILL_VALUE;
      end
      if (!bus.left_avail) begin
        for (int i = 9; i <= 12; i++) smp[i] <= FILL_VALUE;
      end
    end else if (xfer) begin
      smp[nbr_slot(cur_grp, idx)] <= bus.nb_data;
      if ((state == F_TOP) && (idx == 2'd3) && !tr_q) begin
        for (int i = 5; i <= 8; i++) smp[i] <= bus.nb_data;
      end
    end
  end

  assign bus.M = smp[0];
  assign bus.A = smp[1];
  assign bus.B = smp[2];
  assign bus.C = smp[3];
  assign bus.D = smp[4];
  assign bus.E = smp[5];
  assign bus.F = smp[6];
  assign bus.G = smp[7];
  assign bus.H = smp[8];
  assign bus.I = smp[9];
  assign bus.J = smp[10];
  assign bus.K = smp[11];
  assign bus.L = smp[12];

`ifdef INTRA4X4_NBR_BLKCNT_EN
  logic [15:0] blk_cnt;

  always_ff @(posedge clk) begin
    if (reset)        blk_cnt <= 16'd0;
    else if (out_acc) blk_cnt <= blk_cnt + 16'd1;
  end

  assign blk_count = blk_cnt;
`endif

endmodule

// File: tb/tb_intra4x4_nbr_loader.sv
// Randomized self-checking bench for intra4x4_nbr_loader against a transaction-level model.
// Also checks blk_count when INTRA4X4_NBR_BLKCNT_EN is defined.
module tb_intra4x4_nbr_loader;
  import intra_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  intra4x4_nbr_loader_if bus();
`ifdef INTRA4X4_NBR_BLKCNT_EN
  logic [15:0] blkCount;
`endif

  intra4x4_nbr_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef INTRA4X4_NBR_BLKCNT_EN
    ,
    .blk_count (blkCount)
`endif
  );

  int passCount = 0;
  int checkCount = 0;
  int cycleNo = 0;
  bit checking = 0;
  int lastLatency;
  int lastXfers;
  logic [7:0] streamQ [$];
  string letters [13] = '{"M","A","B","C","D","E","F","G","H","I","J","K","L"};

  logic [7:0] dutVals [13];
  assign dutVals[0]  = bus.M;
  assign dutVals[1]  = bus.A;
  assign dutVals[2]  = bus.B;
  assign dutVals[3]  = bus.C;
  assign dutVals[4]  = bus.D;
  assign dutVals[5]  = bus.E;
  assign dutVals[6]  = bus.F;
  assign dutVals[7]  = bus.G;
  assign dutVals[8]  = bus.H;
  assign dutVals[9]  = bus.I;
  assign dutVals[10] = bus.J;
  assign dutVals[11] = bus.K;
  assign dutVals[12] = bus.L;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Transaction-level model: a block is idle, loading (waiting for N samples) or presenting.
  typedef enum int {PH_IDLE, PH_LOAD, PH_OUT} phase_t;
  phase_t mPhase = PH_IDLE;
  logic [7:0] mVals [13];
  logic [7:0] got [$];
  bit mTl, mTop, mTr, mLeft;
  int mNeed;
  logic [15:0] mCount = 16'd0;

  function automatic void buildBundle();
    if (mTl) mVals[0] = got.pop_front(); else mVals[0] = FILL_VALUE;
    for (int i = 0; i < 4; i++) begin
      if (mTop) mVals[1 + i] = got.pop_front(); else mVals[1 + i] = FILL_VALUE;
    end
    for (int i = 0; i < 4; i++) begin
      if (!mTop)    mVals[5 + i] = FILL_VALUE;
      else if (mTr) mVals[5 + i] = got.pop_front();
      else          mVals[5 + i] = mVals[4];
    end
    for (int i = 0; i < 4; i++) begin
      if (mLeft) mVals[9 + i] = got.pop_front(); else mVals[9 + i] = FILL_VALUE;
    end
  endfunction

  always @(posedge clk) begin
    cycleNo++;
    if (reset) begin
      mPhase = PH_IDLE;
      for (int i = 0; i < 13; i++) mVals[i] = 8'd0;
      mCount = 16'd0;
      got.delete();
    end else begin
      case (mPhase)
        PH_IDLE: if (bus.start) begin
          mTl = bus.tl_avail; mTop = bus.top_avail; mTr = bus.tr_avail; mLeft = bus.left_avail;
          mNeed = (mTl ? 1 : 0) + (mTop ? 4 : 0) + ((mTop && mTr) ? 4 : 0) + (mLeft ? 4 : 0);
          got.delete();
          if (mNeed == 0) begin
            buildBundle();
            mPhase = PH_OUT;
          end else mPhase = PH_LOAD;
        end
        PH_LOAD: if (bus.nb_valid) begin
          got.push_back(bus.nb_data);
          if (got.size() == mNeed) begin
            buildBundle();
            mPhase = PH_OUT;
          end
        end
        default: if (bus.out_ready) begin
          mPhase = PH_IDLE;
          mCount = mCount + 16'd1;
        end
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    if (checking) begin
      checkOutput("start_ready", bus.start_ready, mPhase == PH_IDLE);
      checkOutput("nb_ready", bus.nb_ready, mPhase == PH_LOAD);
      checkOutput("out_valid", bus.out_valid, mPhase == PH_OUT);
      if (mPhase != PH_LOAD) begin
        for (int i = 0; i < 13; i++) checkOutput({"sample_", letters[i]}, dutVals[i], mVals[i]);
      end
`ifdef INTRA4X4_NBR_BLKCNT_EN
      checkOutput("blk_count", blkCount, mCount);
`endif
    end
  end

  function automatic void genStream(input bit tl, input bit top, input bit tr, input bit left);
    int n;
    n = (tl ? 1 : 0) + (top ? 4 : 0) + ((top && tr) ? 4 : 0) + (left ? 4 : 0);
    streamQ.delete();
    for (int i = 0; i < n; i++) streamQ.push_back(8'($urandom_range(1, 255)));
  endfunction

  function automatic void fixedStream(input int base);
    streamQ.delete();
    for (int i = 0; i < 13; i++) streamQ.push_back(8'(base + i));
  endfunction

  task automatic applyStimulus(input bit tl, input bit top, input bit tr, input bit left,
                               input int gapPct, input int holdCycles, input int abortAt, input bit noise);
    int k = 0;
    int guard = 0;
    int startCyc;
    bit pv = 0;
    bit pr = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.tl_avail = tl; bus.top_avail = top; bus.tr_avail = tr; bus.left_avail = left;
    startCyc = cycleNo;
    @(negedge clk);
    bus.start = 1'b0;
    while (1) begin
      if (pv && pr) k++;
      if (bus.out_valid) break;
      if (guard >= 400) begin
        checkOutput("load_timeout", 0, 1);
        break;
      end
      guard++;
      if (abortAt >= 0 && k == abortAt) begin
        reset = 1'b1; bus.nb_valid = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        checkOutput("abort_out_valid", bus.out_valid, 0);
        checkOutput("abort_start_ready", bus.start_ready, 1);
        checkOutput("abort_nb_ready", bus.nb_ready, 0);
        checkOutput("abort_A", bus.A, 0);
        checkOutput("abort_M", bus.M, 0);
        reset = 1'b0;
        return;
      end
      bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.tl_avail = 1'($urandom_range(0, 1)); bus.top_avail = 1'($urandom_range(0, 1));
      bus.tr_avail = 1'($urandom_range(0, 1)); bus.left_avail = 1'($urandom_range(0, 1));
      bus.nb_valid = (k < streamQ.size()) && ($urandom_range(0, 99) >= gapPct);
      bus.nb_data  = (k < streamQ.size()) ? streamQ[k] : 8'($urandom);
      pv = bus.nb_valid;
      pr = bus.nb_ready;
      @(negedge clk);
    end
    lastXfers = k;
    lastLatency = cycleNo - startCyc;
    for (int h = 0; h < holdCycles; h++) begin
      bus.out_ready = 1'b0;
      bus.start = noise;
      bus.nb_valid = 1'($urandom_range(0, 1));
      bus.nb_data = 8'($urandom);
      @(negedge clk);
    end
    bus.out_ready = 1'b1; bus.start = noise; bus.nb_valid = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0; bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.tl_avail = 1'b0; bus.top_avail = 1'b0; bus.tr_avail = 1'b0;
    bus.left_avail = 1'b0; bus.nb_valid = 1'b0; bus.nb_data = 8'd0; bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_start_ready", bus.start_ready, 1);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_nb_ready", bus.nb_ready, 0);
    checkOutput("rst_A", bus.A, 0);
    checkOutput("rst_L", bus.L, 0);
    reset = 1'b0;
    checking = 1'b1;

    $display("[TB] full load, no stalls");
    streamQ.delete();
    streamQ.push_back(8'd10);
    for (int i = 0; i < 8; i++) streamQ.push_back(8'(20 + i));
    for (int i = 0; i < 4; i++) streamQ.push_back(8'(30 + i));
    applyStimulus(1, 1, 1, 1, 0, 0, -1, 0);
    checkOutput("t1_latency", lastLatency, 14);
    checkOutput("t1_xfers", lastXfers, 13);
    checkOutput("t1_M", bus.M, 10);
    checkOutput("t1_A", bus.A, 20);
    checkOutput("t1_E", bus.E, 24);
    checkOutput("t1_H", bus.H, 27);
    checkOutput("t1_L", bus.L, 33);

    $display("[TB] top-right unavailable");
    streamQ.delete();
    streamQ.push_back(8'd3);
    for (int i = 0; i < 4; i++) streamQ.push_back(8'(5 + i));
    for (int i = 0; i < 4; i++) streamQ.push_back(8'(50 + i));
    applyStimulus(1, 1, 0, 1, 0, 0, -1, 0);
    checkOutput("t2_xfers", lastXfers, 9);
    checkOutput("t2_latency", lastLatency, 10);
    checkOutput("t2_M", bus.M, 3);
    checkOutput("t2_D", bus.D, 8);
    checkOutput("t2_E", bus.E, 8);
    checkOutput("t2_H", bus.H, 8);
    checkOutput("t2_I", bus.I, 50);

    $display("[TB] nothing available");
    streamQ.delete();
    applyStimulus(0, 0, 1, 0, 0, 0, -1, 0);
    checkOutput("t3_latency", lastLatency, 1);
    checkOutput("t3_xfers", lastXfers, 0);
    checkOutput("t3_M", bus.M, 128);
    checkOutput("t3_A", bus.A, 128);
    checkOutput("t3_E", bus.E, 128);
    checkOutput("t3_L", bus.L, 128);

    $display("[TB] stream gaps and held output");
    streamQ.delete();
    streamQ.push_back(8'd10);
    for (int i = 0; i < 8; i++) streamQ.push_back(8'(20 + i));
    for (int i = 0; i < 4; i++) streamQ.push_back(8'(30 + i));
    applyStimulus(1, 1, 1, 1, 40, 5, -1, 0);
    checkOutput("t4_M", bus.M, 10);
    checkOutput("t4_H", bus.H, 27);
    checkOutput("t4_L", bus.L, 33);
    for (int n = 0; n < 10; n++) begin
      bit tl, top, tr, left;
      tl = 1'($urandom_range(0, 1)); top = 1'($urandom_range(0, 1));
      tr = 1'($urandom_range(0, 1)); left = 1'($urandom_range(0, 1));
      genStream(tl, top, tr, left);
      applyStimulus(tl, top, tr, left, 30, $urandom_range(0, 3), -1, 0);
    end

    $display("[TB] reset mid-load");
    fixedStream(40);
    applyStimulus(1, 1, 1, 1, 0, 0, 6, 0);
    fixedStream(100);
    applyStimulus(1, 1, 1, 1, 0, 0, -1, 0);
    checkOutput("t5_M", bus.M, 100);
    checkOutput("t5_L", bus.L, 112);

    $display("[TB] start pulses during fetch and output");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      genStream(1, 1, 1, 1);
      applyStimulus(1, 1, 1, 1, 20, 3, -1, 1);
    end
`ifdef INTRA4X4_NBR_BLKCNT_EN
    checkOutput("t6_blk_count", blkCount, 3);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
